// File: rtl/mcu_irq_sched.sv
// mcu_irq_sched: pending-event collector with round-robin fetch/ack over the MCU byte link.
module mcu_irq_sched #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] int_req,
  output logic [NSRC-1:0] int_ack,
  output logic            mcu_int,
  input  logic            mcu_strobe,
  input  logic            mcu_start,
  input  logic [7:0]      mcu_din,
  output logic [7:0]      mcu_dout
);
  typedef enum logic [1:0] {IDLE, MASK_WR, DONE} state_t;
  state_t r_state, w_state_n;
  logic [NSRC-1:0] r_req_d, r_pending, r_mask;
  logic [NSRC-1:0] w_elig, w_rise, w_ack_n, w_mask_n;
  logic [2:0] r_rr, w_rr_n, w_gnt;
  logic [3:0] w_best, w_dist;
  logic [7:0] w_dout_n;
  logic w_cmd, w_data, w_get;
  assign w_cmd  = mcu_strobe & mcu_start;
  assign w_data = mcu_strobe & ~mcu_start & (r_state == MASK_WR);
  assign w_elig = r_pending & r_mask;
  assign w_rise = int_req & ~r_req_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb
    w_state_n = w_cmd ? (mcu_din == 8'h62 ? MASK_WR : DONE) : w_data ? DONE : r_state;
  // winner is the eligible source at the smallest distance past the last grant
  always_comb begin
    w_best = 4'(NSRC);
    w_gnt  = '0;
    w_dist = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_dist = 4'((i + 2 * NSRC - 1 - int'(r_rr)) % NSRC);
      if (w_elig[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_gnt  = 3'(i);
      end
    end
  end
  always_comb begin
    w_get    = w_cmd && mcu_din == 8'h61 && |w_elig;
    w_ack_n  = w_get ? NSRC'(1) << w_gnt : '0;
    w_rr_n   = w_get ? w_gnt : r_rr;
    w_mask_n = w_data ? mcu_din[NSRC-1:0] : r_mask;
    w_dout_n = !w_cmd ? mcu_dout :
               mcu_din == 8'h61 ? (w_get ? {1'b1, 4'b0000, w_gnt} : 8'h00) :
               mcu_din == 8'h62 ? 8'(r_mask) :
               mcu_din == 8'h63 ? 8'(r_pending) : 8'h00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_req_d   <= '0;
      r_pending <= '0;
      r_mask    <= '1;
      r_rr      <= 3'(NSRC - 1);
      int_ack   <= '0;
      mcu_int   <= 1'b0;
      mcu_dout  <= 8'h00;
    end else begin
      r_req_d   <= int_req;
      r_pending <= (r_pending & ~w_ack_n) | w_rise;
      r_mask    <= w_mask_n;
      r_rr      <= w_rr_n;
      int_ack   <= w_ack_n;
      mcu_int   <= |w_elig;
      mcu_dout  <= w_dout_n;
    end
endmodule

// File: tb/tb_mcu_irq_sched.sv
// tb_mcu_irq_sched: directed vector table, reset corner case and random traffic against a reference model.
module tb_mcu_irq_sched;
  localparam int NSRC = 4;
  localparam logic [7:0] FULL = 8'h0F;
  logic clk = 0, reset = 1, mcu_strobe = 0, mcu_start = 0, mcu_int;
  logic [NSRC-1:0] int_req = '0, int_ack;
  logic [7:0] mcu_din = '0, mcu_dout;
  int n_chk = 0, n_fail = 0, cyc = 0;
  mcu_irq_sched #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_ack(int_ack), .mcu_int(mcu_int),
    .mcu_strobe(mcu_strobe), .mcu_start(mcu_start), .mcu_din(mcu_din), .mcu_dout(mcu_dout)
  );
  always #5 clk = ~clk;
  bit [7:0] m_pend, m_mask, m_reqd, m_dout, m_ack;
  int m_rr;
  bit m_mwr, m_int;
  task automatic model_reset();
    m_pend = 0; m_mask = FULL; m_reqd = 0; m_dout = 0; m_ack = 0;
    m_rr = NSRC - 1; m_mwr = 0; m_int = 0;
  endtask
  task automatic model_tick(input bit r, input bit s, input bit t, input bit [7:0] d, input bit [7:0] q);
    bit [7:0] rise, clr;
    bit nint;
    int g;
    if (r) begin
      model_reset();
      return;
    end
    nint = |(m_pend & m_mask);
    rise = q & ~m_reqd;
    m_reqd = q;
    clr = 0;
    m_ack = 0;
    if (s && t) begin
      m_mwr = (d == 8'h62);
      if (d == 8'h61) begin
        g = -1;
        for (int k = 1; k <= NSRC && g < 0; k++)
          if (m_pend[(m_rr + k) % NSRC] && m_mask[(m_rr + k) % NSRC]) g = (m_rr + k) % NSRC;
        if (g >= 0) begin
          clr[g] = 1; m_ack[g] = 1; m_rr = g; m_dout = 8'h80 + 8'(g);
        end else m_dout = 8'h00;
      end else if (d == 8'h62) m_dout = m_mask;
      else if (d == 8'h63) m_dout = m_pend;
      else m_dout = 8'h00;
    end else if (s && m_mwr) begin
      m_mask = d & FULL;
      m_mwr = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_int = nint;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input bit r, input bit s, input bit t, input logic [7:0] d, input logic [3:0] q);
    reset = r; mcu_strobe = s; mcu_start = t; mcu_din = d; int_req = q;
    model_tick(r, s, t, d, 8'(q));
    @(posedge clk); #1;
    cyc++;
    chk("dout_model", mcu_dout, m_dout);
    chk("ack_model", 8'(int_ack), m_ack);
    chk("int_model", 8'(mcu_int), 8'(m_int));
  endtask
  typedef struct {
    bit rst, stb, st;
    logic [7:0] din;
    logic [3:0] req;
    logic [7:0] dout;
    logic [3:0] ack;
    bit irq;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit r, bit s, bit t, logic [7:0] d, logic [3:0] q, logic [7:0] o, logic [3:0] a, bit i);
    vec_t v;
    v.rst = r; v.stb = s; v.st = t; v.din = d; v.req = q; v.dout = o; v.ack = a; v.irq = i;
    return v;
  endfunction
  initial begin
    model_reset();
    tbl.push_back(mk(0,0,0,8'h00,4'b0100,8'h00,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0100,8'h00,4'b0000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b0100,8'h82,4'b0100,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0100,8'h82,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0000,8'h82,4'b0000,0));
    tbl.push_back(mk(1,0,0,8'h00,4'b0000,8'h00,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b1111,8'h00,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h61,4'b1111,8'h80,4'b0001,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b1111,8'h81,4'b0010,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b1111,8'h82,4'b0100,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b1111,8'h83,4'b1000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b1111,8'h00,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b1111,8'h00,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0000,8'h00,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0010,8'h00,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h61,4'b0010,8'h81,4'b0010,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b1001,8'h81,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h61,4'b1001,8'h83,4'b1000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b1001,8'h80,4'b0001,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0000,8'h80,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0001,8'h80,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h62,4'b0001,8'h0F,4'b0000,1));
    tbl.push_back(mk(0,1,0,8'h0E,4'b0001,8'h0F,4'b0000,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0001,8'h0F,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h61,4'b0001,8'h00,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h63,4'b0001,8'h01,4'b0000,0));
    tbl.push_back(mk(0,1,1,8'h62,4'b0001,8'h0E,4'b0000,0));
    tbl.push_back(mk(0,1,0,8'h0F,4'b0001,8'h0E,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0001,8'h0E,4'b0000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b0001,8'h80,4'b0001,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0101,8'h80,4'b0000,0));
    tbl.push_back(mk(0,0,0,8'h00,4'b0001,8'h80,4'b0000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b0101,8'h82,4'b0100,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0101,8'h82,4'b0000,1));
    tbl.push_back(mk(0,1,1,8'h61,4'b0101,8'h82,4'b0100,1));
    tbl.push_back(mk(0,0,0,8'h00,4'b0000,8'h82,4'b0000,0));
    step(1, 0, 0, 8'h00, 4'b0000);
    step(1, 0, 0, 8'h00, 4'b0000);
    chk("reset_dout", mcu_dout, 8'h00);
    chk("reset_int", 8'(mcu_int), 8'h00);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stb, tbl[i].st, tbl[i].din, tbl[i].req);
      chk("vec_dout", mcu_dout, tbl[i].dout);
      chk("vec_ack", 8'(int_ack), 8'(tbl[i].ack));
      chk("vec_int", 8'(mcu_int), 8'(tbl[i].irq));
    end
    // reset lands between the MASK command and its data byte
    step(0, 1, 1, 8'h62, 4'b0000);
    chk("mask_cmd_reply", mcu_dout, 8'h0F);
    reset = 1;
    model_reset();
    #1;
    chk("async_reset_dout", mcu_dout, 8'h00);
    step(1, 0, 0, 8'h00, 4'b0000);
    step(0, 1, 0, 8'h00, 4'b0001);
    step(0, 0, 0, 8'h00, 4'b0001);
    chk("mask_kept_int", 8'(mcu_int), 8'h01);
    step(0, 1, 1, 8'h62, 4'b0001);
    chk("mask_kept_reply", mcu_dout, 8'h0F);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      int sel;
      sel = $urandom_range(0, 4);
      d = sel == 0 ? 8'h61 : sel == 1 ? 8'h62 : sel == 2 ? 8'h63 : sel == 3 ? 8'h61 : 8'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, d,
           $urandom_range(0, 3) == 0 ? 4'($urandom) : int_req);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mcu_irq_sched.md
# mcu_irq_sched

Interrupt scheduler for the MCU link. Collects event requests from core-side agents (HID, OSD, SD card, system), holds them pending, raises a single level interrupt line to the MCU, and lets the MCU fetch and acknowledge one source per SPI transaction in round-robin order. It is a byte-interface target behind the MCU SPI front end and is addressed like any other target (strobe, start, data in, data out).

## Interface
- NSRC, 4, number of request sources (legal range 1..8)
- clk  in  1  system clock; all logic is synchronous to it
- reset  in  1  asynchronous, active-high reset
- int_req  in  NSRC  per-source event request; rising edge sets pending
- int_ack  out  NSRC  one-cycle pulse to the source whose event was fetched
- mcu_int  out  1  level interrupt to MCU: high while any masked-in source is pending
- mcu_strobe  in  1  one-cycle byte strobe for this target
- mcu_start  in  1  high with the strobe of the first data byte of a transaction
- mcu_din  in  8  byte from MCU, valid with mcu_strobe
- mcu_dout  out  8  reply byte to MCU, registered

## Operation
- Reset values: pending=0, mask=all NSRC bits 1, rr_ptr=NSRC-1, state=IDLE, int_ack=0, mcu_int=0, mcu_dout=0x00, int_req history=0.
- Edge detect: req_d <= int_req each cycle; rise = int_req & ~req_d. A level held high sets pending once.
- Pending set: pending[i] <= 1 on rise[i]. Clear on fetch (below). Set and clear of the same bit in the same cycle: set wins (bit stays 1, no event lost).
- mcu_int <= |(pending & mask[NSRC-1:0]), registered.
- Parser state machine, states IDLE, MASK_WR, DONE:
  - Any mcu_strobe with mcu_start = command byte; it is decoded from every state (new transaction aborts an unfinished one).
  - 0x61 GET: elig = pending & mask. If elig != 0, pick the first set bit searching from rr_ptr+1 upward with wrap at NSRC; set grant index g; clear pending[g]; pulse int_ack[g]; rr_ptr <= g; mcu_dout <= {1'b1, 4'b0000, g[2:0]}. If elig == 0: mcu_dout <= 0x00, no side effects. Next state DONE.
  - 0x62 MASK: mcu_dout <= mask zero-extended to 8 bits; next state MASK_WR. Next non-start strobe in MASK_WR: mask <= mcu_din[NSRC-1:0] (upper bits ignored), state DONE.
  - 0x63 STATUS: mcu_dout <= raw pending zero-extended; no side effects; state DONE.
  - Any other command: mcu_dout <= 0x00; state DONE.
  - Non-start strobes in DONE or IDLE are ignored; mcu_dout holds its value.
- Masked pending bits stay pending; unmasking them re-asserts mcu_int.

## Timing
- int_req rise at cycle n (first cycle seen high at clk edge n) -> pending set at n+1 -> mcu_int high at n+2.
- GET strobe at cycle n -> mcu_dout, int_ack pulse, pending clear, rr_ptr update all at n+1; mcu_int reflects the clear at n+2.
- MASK/STATUS reply on mcu_dout at n+1 after command strobe; mask write takes effect at n+1 after the data strobe, mcu_int follows at n+2.
- int_ack is exactly one cycle wide; never more than one bit set.
- Reset asserted mid-transaction: all state returns to reset values immediately; first strobe after release is decoded only if mcu_start is high.
- Back-to-back strobes on consecutive cycles are handled; each produces its effect one cycle later.

## Test plan
- Reset, then int_req=4'b0100 rise -> pending=0x4 at +1, mcu_int=1 at +2; GET -> mcu_dout=0x82, int_ack=4'b0100 one cycle, mcu_int=0 two cycles after the strobe.
- All four requests pending, four GET transactions -> replies 0x80, 0x81, 0x82, 0x83 in order; fifth GET -> 0x00 with no int_ack.
- rr_ptr=1 with sources 0 and 3 pending -> GET returns 0x83, then 0x80 (wrap-around).
- MASK command then data 0x0E with source 0 pending -> first reply 0x0F, mcu_int=0, GET -> 0x00; STATUS -> 0x01; MASK 0x0F -> mcu_int=1.
- int_req[2] rises on the same cycle GET grants source 2 -> int_ack[2] pulses and pending[2] remains 1; next GET -> 0x82 again.
- Reset asserted between MASK command and its data byte -> mask=0x0F, state IDLE; following non-start strobe with 0x00 leaves mask unchanged.
